wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Write-back end of the execute-stage result interface.
- Consumes the execute result triple (destination address, write enable, write data) and carries it through two internal pipeline registers, MEM then WB.
- Commits the result into a 32-entry general-purpose register file.
- Serves two operand read ports to decode, with forwarding from the execute input, MEM and WB so that back-to-back dependent instructions read correct values.

Parameters:
- DATA_WIDTH, 32, register and result width.
- ADDR_WIDTH, 5, register address width; array depth is 2**ADDR_WIDTH.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  holds MEM and inserts a bubble into WB.
- wd_input  input  ADDR_WIDTH  execute-stage destination register.
- wreg_input  input  1  execute-stage write enable.
- wdata_input  input  DATA_WIDTH  execute-stage result.
- re1_input  input  1  read port 1 enable.
- raddr1_input  input  ADDR_WIDTH  read port 1 address.
- re2_input  input  1  read port 2 enable.
- raddr2_input  input  ADDR_WIDTH  read port 2 address.
- rdata1_output  output  DATA_WIDTH  read port 1 data, combinational.
- rdata2_output  output  DATA_WIDTH  read port 2 data, combinational.
- wb_wd_output  output  ADDR_WIDTH  WB-stage destination, for trace.
- wb_wreg_output  output  1  WB-stage write enable, for trace.
- wb_wdata_output  output  DATA_WIDTH  WB-stage data, for trace.

Behaviour:
- Reset:
  - Asserting reset clears immediately, independent of clock: MEM and WB stages (wd=0, wreg=0, wdata=0) and all array entries.
  - While reset is high, rdata1/rdata2 = 0 and all wb_* outputs = 0.
  - Reset mid-stream discards every in-flight write.
- Each rising clock edge (reset low), in this order of effect; all updates use pre-edge values:
  - Commit: if WB.wreg=1 and WB.wd!=0, then array[WB.wd] <= WB.wdata.
  - WB update: WB <= stall ? {0,0,0} : MEM.
  - MEM update: MEM <= stall ? MEM : {wd_input, wreg_input, wdata_input}.
- Register 0:
  - Never written.
  - Any read of address 0 returns 0, regardless of forwarding sources.
- Latency:
  - A result presented at execute is in MEM after edge 1, in WB after edge 2, and in the array after edge 3.
  - Forwarding makes it readable in the same cycle it is presented.
- Read port n, combinational, priority high to low:
  1. re=0 -> 0.
  2. raddr=0 -> 0.
  3. wreg_input=1 and wd_input==raddr -> wdata_input.
  4. MEM.wreg=1 and MEM.wd==raddr -> MEM.wdata.
  5. WB.wreg=1 and WB.wd==raddr -> WB.wdata.
  6. Otherwise -> array[raddr].
- Younger results always win when several stages target the same register.
- Stall:
  - MEM holds its contents indefinitely.
  - WB drains on the first stalled edge, then holds the bubble.
  - A MEM entry held under stall still forwards.
  - Upstream keeps the execute inputs stable during stall; inputs presented while stall=1 are not captured.
- Both read ports may hit the same address or the same forwarding source simultaneously; each resolves independently.
- A write with wreg=1 to address 0 flows through the pipeline but never commits and never forwards.

Optional Feature:
- Macro: REGFILE_FORWARD_EN.
- Defined: read priority exactly as above (forwarding from execute, MEM and WB).
- Undefined:
  - Steps 3-5 are removed; reads return array[raddr] (0 for address 0 or re=0).
  - A dependent read sees the new value only from the cycle after the commit edge.
  - Pipeline and commit timing are otherwise unchanged.

Test Plan:
- Reset clear: reset=1 mid-stream, then read r5 and r31 -> rdata=0 immediately, wb_wreg_output=0, no later commit of discarded writes.
- Basic write: execute wd=3, wreg=1, wdata=0x1234ABCD for one cycle, then idle; read r3 after edge 3 -> 0x1234ABCD, and wb_wd_output=3 during cycle 3.
- Forward priority: consecutive writes r7=0x11, r7=0x22, r7=0x33 with a read of r7 each cycle -> 0x11, 0x22, 0x33 (youngest wins); after drain, array r7=0x33.
- Zero register: write r0=0xFFFFFFFF and read r0 on both ports for 4 cycles -> always 0.
- Stall: MEM holds r9=0x55, stall=1 for 3 cycles -> WB bubble (wb_wreg=0) from the first stalled edge; r9 read -> 0x55 throughout; after release, r9 commits 2 edges later.
- Without REGFILE_FORWARD_EN: write r4=0xA5, read r4 each cycle -> 0 until after edge 3, then 0xA5.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Execute-result, stall and operand-read bus between the pipeline and wb_regfile.
interface wb_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  stall;
  logic [ADDR_WIDTH-1:0] wd_input;
  logic                  wreg_input;
  logic [DATA_WIDTH-1:0] wdata_input;
  logic                  re1_input;
  logic [ADDR_WIDTH-1:0] raddr1_input;
  logic                  re2_input;
  logic [ADDR_WIDTH-1:0] raddr2_input;
  logic [DATA_WIDTH-1:0] rdata1_output;
  logic [DATA_WIDTH-1:0] rdata2_output;
  logic [ADDR_WIDTH-1:0] wb_wd_output;
  logic                  wb_wreg_output;
  logic [DATA_WIDTH-1:0] wb_wdata_output;

  modport master (
    output stall, wd_input, wreg_input, wdata_input,
    output re1_input, raddr1_input, re2_input, raddr2_input,
    input  rdata1_output, rdata2_output,
    input  wb_wd_output, wb_wreg_output, wb_wdata_output
  );

  modport slave (
    input  stall, wd_input, wreg_input, wdata_input,
    input  re1_input, raddr1_input, re2_input, raddr2_input,
    output rdata1_output, rdata2_output,
    output wb_wd_output, wb_wreg_output, wb_wdata_output
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back end: MEM/WB pipeline registers, 32-entry register file, two read ports.
// Build option REGFILE_FORWARD_EN: reads forward from execute, MEM and WB (youngest first).
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic         clock,
  input  logic         reset,
  wb_regfile_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] mem_wd_r;
  logic                  mem_wreg_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [ADDR_WIDTH-1:0] wb_wd_r;
  logic                  wb_wreg_r;
  logic [DATA_WIDTH-1:0] wb_wdata_r;
  logic [DATA_WIDTH-1:0] regs_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata1_s;
  logic [DATA_WIDTH-1:0] rdata2_s;

  // MEM/WB pipeline: stall freezes MEM and drains WB to a bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_wd_r    <= '0;
      mem_wreg_r  <= 1'b0;
      mem_wdata_r <= '0;
      wb_wd_r     <= '0;
      wb_wreg_r   <= 1'b0;
      wb_wdata_r  <= '0;
    end else if (bus.stall) begin
      wb_wd_r     <= '0;
      wb_wreg_r   <= 1'b0;
      wb_wdata_r  <= '0;
    end else begin
      wb_wd_r     <= mem_wd_r;
      wb_wreg_r   <= mem_wreg_r;
      wb_wdata_r  <= mem_wdata_r;
      mem_wd_r    <= bus.wd_input;
      mem_wreg_r  <= bus.wreg_input;
      mem_wdata_r <= bus.wdata_input;
    end
  end

  // Register array commit from WB; entry 0 is never written
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_wreg_r && (wb_wd_r != '0)) begin
      regs_r[wb_wd_r] <= wb_wdata_r;
    end
  end

  // Read port 1 resolution
  always_comb begin
    rdata1_s = '0;
    if (reset || !bus.re1_input || (bus.raddr1_input == '0)) begin
      rdata1_s = '0;
`ifdef REGFILE_FORWARD_EN
    end else if (bus.wreg_input && (bus.wd_input == bus.raddr1_input)) begin
      rdata1_s = bus.wdata_input;
    end else if (mem_wreg_r && (mem_wd_r == bus.raddr1_input)) begin
      rdata1_s = mem_wdata_r;
    end else if (wb_wreg_r && (wb_wd_r == bus.raddr1_input)) begin
      rdata1_s = wb_wdata_r;
`endif
    end else begin
      rdata1_s = regs_r[bus.raddr1_input];
    end
  end

  // Read port 2 resolution, independent of port 1
  always_comb begin
    rdata2_s = '0;
    if (reset || !bus.re2_input || (bus.raddr2_input == '0)) begin
      rdata2_s = '0;
`ifdef REGFILE_FORWARD_EN
    end else if (bus.wreg_input && (bus.wd_input == bus.raddr2_input)) begin
      rdata2_s = bus.wdata_input;
    end else if (mem_wreg_r && (mem_wd_r == bus.raddr2_input)) begin
      rdata2_s = mem_wdata_r;
    end else if (wb_wreg_r && (wb_wd_r == bus.raddr2_input)) begin
      rdata2_s = wb_wdata_r;
`endif
    end else begin
      rdata2_s = regs_r[bus.raddr2_input];
    end
  end

  assign bus.rdata1_output   = rdata1_s;
  assign bus.rdata2_output   = rdata2_s;
  assign bus.wb_wd_output    = wb_wd_r;
  assign bus.wb_wreg_output  = wb_wreg_r;
  assign bus.wb_wdata_output = wb_wdata_r;
endmodule
